// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared defaults and helpers for the t_ff toggle flip-flop bank.
//   DEF_WIDTH  default number of toggle bits
//   DEF_CNT_W  default toggle-event counter width
//   sat_inc    saturating increment, returns min(cnt + 1, max_val)
package t_ff_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/t_ff_bit.sv
// t_ff_bit: single toggle flip-flop cell.
// Ports:
//   clk      clock, state updates on posedge
//   rstn     synchronous active-high reset (1 = reset)
//   t        toggle request
//   rst_val  value loaded into q on reset
//   q        registered state
module t_ff_bit (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rstn) q <= rst_val;
    else      q <= q ^ t;
  end

endmodule

// File: rtl/t_ff.sv
// t_ff: bank of WIDTH independent toggle flip-flops.
// Each q bit inverts on posedge clk when its t bit is 1, else holds.
// Ports:
//   clk         clock, all state updates on posedge
//   rstn        synchronous active-high reset (1 = reset), priority over t
//   t           per-bit toggle request
//   q           registered state
//   qn          ~q, combinational
//   toggle_cnt  saturating count of non-reset edges with |t (T_FF_TOGGLE_CNT_EN only)
// Optional feature macro: T_FF_TOGGLE_CNT_EN
module t_ff
  import t_ff_pkg::*;
#(
  parameter int unsigned            WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]       RST_VAL = '0,
  parameter int unsigned            CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`ifdef T_FF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_bit u_bit (
      .clk     (clk),
      .rstn    (rstn),
      .t       (t[i]),
      .rst_val (RST_VAL[i]),
      .q       (q[i])
    );
  end

  assign qn = ~q;

  // Counter arithmetic goes through a 32-bit helper, so the width is bounded.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("t_ff: CNT_W must be in 1..31");
  end

`ifdef T_FF_TOGGLE_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rstn)    cnt_q <= '0;
    else if (|t) cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_t_ff.sv
module tb_t_ff;

  logic       clk = 1'b0;
  logic       rst1, t1;
  logic       q1, qn1;
  logic       rst4;
  logic [3:0] t4, q4, qn4;
`ifdef T_FF_TOGGLE_CNT_EN
  logic [7:0] cnt1;
  logic [1:0] cnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t_ff #(.WIDTH(1), .RST_VAL(1'b0), .CNT_W(8)) u1 (
    .clk  (clk),
    .rstn (rst1),
    .t    (t1),
    .q    (q1),
    .qn   (qn1)
`ifdef T_FF_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt1)
`endif
  );

  t_ff #(.WIDTH(4), .RST_VAL(4'b1010), .CNT_W(2)) u4 (
    .clk  (clk),
    .rstn (rst4),
    .t    (t4),
    .q    (q4),
    .qn   (qn4)
`ifdef T_FF_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; t1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_w1 edge%0d q=%b qn=%b exp q=0 qn=1", i, q1, qn1);
      end
    end
  endtask

  task automatic test_toggle();
    logic exp_q [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst1 = 1'b0; t1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q1 !== exp_q[i] || qn1 !== ~exp_q[i]) begin
        errors++;
        $display("FAIL toggle_w1 edge%0d q=%b qn=%b exp q=%b", i, q1, qn1, exp_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    rst1 = 1'b1; t1 = 1'b0;
    tick();
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
        errors++;
        $display("FAIL hold0 edge%0d q=%b qn=%b exp q=0 qn=1", i, q1, qn1);
      end
    end
    t1 = 1'b1;
    tick();
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL single_toggle q=%b exp 1", q1);
    end
    t1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q1 !== 1'b1 || qn1 !== 1'b0) begin
        errors++;
        $display("FAIL hold1 edge%0d q=%b qn=%b exp q=1 qn=0", i, q1, qn1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    // q1 is 1 here; reset must win over t on this edge
    rst1 = 1'b1; t1 = 1'b1;
    tick();
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority q=%b exp 0", q1);
    end
    rst1 = 1'b0; t1 = 1'b1;
    tick();
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL resume_after_reset q=%b exp 1", q1);
    end
    // reset pulse confined between edges must not act
    t1 = 1'b0;
    #2 rst1 = 1'b1;
    #2 rst1 = 1'b0;
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_pulse_between q=%b exp 1", q1);
    end
    tick();
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_pulse_after_edge q=%b exp 1", q1);
    end
  endtask

  task automatic test_width4();
    rst4 = 1'b1; t4 = 4'b1111;
    tick();
    checks++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
      errors++;
      $display("FAIL reset_w4 q=%b qn=%b exp q=1010 qn=0101", q4, qn4);
    end
    rst4 = 1'b0; t4 = 4'b0110;
    tick();
    checks++;
    if (q4 !== 4'b1100 || qn4 !== 4'b0011) begin
      errors++;
      $display("FAIL w4_t0110 q=%b qn=%b exp q=1100", q4, qn4);
    end
    t4 = 4'b1111;
    tick();
    checks++;
    if (q4 !== 4'b0011 || qn4 !== 4'b1100) begin
      errors++;
      $display("FAIL w4_t1111 q=%b qn=%b exp q=0011", q4, qn4);
    end
    t4 = 4'b0000;
    tick();
    checks++;
    if (q4 !== 4'b0011) begin
      errors++;
      $display("FAIL w4_hold q=%b exp 0011", q4);
    end
  endtask

`ifdef T_FF_TOGGLE_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [3:0] pat   [5] = '{4'b0001, 4'b1000, 4'b0110, 4'b1111, 4'b0100};
    rst4 = 1'b1; t4 = 4'b1111;
    tick();
    checks++;
    if (cnt4 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_reset cnt=%0d exp 0", cnt4);
    end
    rst4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t4 = pat[i];
      tick();
      checks++;
      if (cnt4 !== exp_c[i]) begin
        errors++;
        $display("FAIL cnt_step%0d cnt=%0d exp %0d", i, cnt4, exp_c[i]);
      end
    end
    t4 = 4'b0000;
    tick();
    checks++;
    if (cnt4 !== 2'd3) begin
      errors++;
      $display("FAIL cnt_hold cnt=%0d exp 3", cnt4);
    end
    rst4 = 1'b1;
    tick();
    checks++;
    if (cnt4 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_rereset cnt=%0d exp 0", cnt4);
    end
    rst4 = 1'b0; t4 = 4'b0000;
    tick();
    checks++;
    if (cnt4 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_idle cnt=%0d exp 0", cnt4);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] qm;
`ifdef T_FF_TOGGLE_CNT_EN
    logic [1:0] cm;
    cm = 2'd0;
`endif
    rst4 = 1'b1; t4 = 4'b0000;
    tick();
    rst4 = 1'b0;
    qm = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      t4 = 4'($urandom_range(0, 15));
      qm = qm ^ t4;
`ifdef T_FF_TOGGLE_CNT_EN
      if (t4 != 4'b0000 && cm != 2'd3) cm = cm + 2'd1;
`endif
      tick();
      checks++;
      if (q4 !== qm || qn4 !== ~qm) begin
        errors++;
        $display("FAIL random%0d t=%b q=%b qn=%b exp q=%b", i, t4, q4, qn4, qm);
      end
`ifdef T_FF_TOGGLE_CNT_EN
      checks++;
      if (cnt4 !== cm) begin
        errors++;
        $display("FAIL random_cnt%0d cnt=%0d exp %0d", i, cnt4, cm);
      end
`endif
    end
  endtask

  initial begin
    rst1 = 1'b1; t1 = 1'b0;
    rst4 = 1'b1; t4 = 4'b0000;
    #1;
    test_reset();
    test_toggle();
    test_hold();
    test_reset_midstream();
    test_width4();
`ifdef T_FF_TOGGLE_CNT_EN
    test_counter();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
